// File: rtl/banco_reg_wb_pkg.sv
// Shared MIPS datapath constants: write-index select codes, fixed register
// indices and the stack pointer reset value.
package banco_reg_wb_pkg;

    typedef enum logic [1:0] {
        RDST_RT = 2'b00,
        RDST_RD = 2'b01,
        RDST_RA = 2'b10,
        RDST_SP = 2'b11
    } regDst_e;

    localparam logic [4:0]  REG_ZERO     = 5'd0;
    localparam logic [4:0]  REG_SP       = 5'd29;
    localparam logic [4:0]  REG_RA       = 5'd31;
    // Also drives the write-data selector's code-000 input, keeping $sp consistent.
    localparam logic [31:0] SP_RESET_VAL = 32'd227;

endpackage

// File: rtl/banco_reg_wb_mux_reg_dst.sv
// Write-register index selector: picks rt, rd, the link register or the
// stack pointer as the destination of the current write-back.
module banco_reg_wb_mux_reg_dst
    import banco_reg_wb_pkg::*;
#(
    parameter logic [4:0] RA_INDEX = REG_RA,
    parameter logic [4:0] SP_INDEX = REG_SP
) (
    input  logic [1:0] sel_i,
    input  logic [4:0] rt_i,
    input  logic [4:0] rd_i,
    output logic [4:0] idx_o
);

    always_comb begin
        idx_o = rt_i;
        case (regDst_e'(sel_i))
            RDST_RT: idx_o = rt_i;
            RDST_RD: idx_o = rd_i;
            RDST_RA: idx_o = RA_INDEX;
            RDST_SP: idx_o = SP_INDEX;
            default: idx_o = rt_i;
        endcase
    end

endmodule

// File: rtl/banco_reg_wb.sv
// 32x32 register bank for the multicycle MIPS write-back stage, with two
// combinational read ports and debug write tracking.
module banco_reg_wb
    import banco_reg_wb_pkg::*;
#(
    parameter logic [31:0] SP_RESET = SP_RESET_VAL,
    parameter logic [4:0]  RA_INDEX = REG_RA,
    parameter logic [4:0]  SP_INDEX = REG_SP,
    parameter bit          BYPASS   = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [1:0]  reg_dst,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [4:0]  write_idx,
    output logic [15:0] write_count
);

    logic [31:0] regFile_q [32];
    logic [4:0]  writeIdx_q;
    logic [15:0] writeCount_q;
    logic [15:0] writeCount_d;
    logic [4:0]  wrIdx;
    logic        wrEn;

    banco_reg_wb_mux_reg_dst #(
        .RA_INDEX (RA_INDEX),
        .SP_INDEX (SP_INDEX)
    ) u_mux_reg_dst (
        .sel_i (reg_dst),
        .rt_i  (rt_addr),
        .rd_i  (rd_addr),
        .idx_o (wrIdx)
    );

    // Writes aimed at $zero are dropped entirely, including the debug tracking.
    assign wrEn         = reg_write && (wrIdx != REG_ZERO);
    assign writeCount_d = writeCount_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regFile_q[i] <= (i == int'(REG_SP)) ? SP_RESET : 32'd0;
            end
            writeIdx_q   <= REG_ZERO;
            writeCount_q <= 16'd0;
        end else if (wrEn) begin
            regFile_q[wrIdx] <= write_data;
            writeIdx_q       <= wrIdx;
            writeCount_q     <= writeCount_d;
        end
    end

    always_comb begin
        read_data1 = regFile_q[read_reg1];
        if (BYPASS && wrEn && (read_reg1 == wrIdx)) begin
            read_data1 = write_data;
        end
        if (read_reg1 == REG_ZERO) begin
            read_data1 = 32'd0;
        end
    end

    always_comb begin
        read_data2 = regFile_q[read_reg2];
        if (BYPASS && wrEn && (read_reg2 == wrIdx)) begin
            read_data2 = write_data;
        end
        if (read_reg2 == REG_ZERO) begin
            read_data2 = 32'd0;
        end
    end

    assign write_idx   = writeIdx_q;
    assign write_count = writeCount_q;

endmodule

// File: tb/tb_banco_reg_wb.sv
// Scoreboard bench for banco_reg_wb: directed writes/reads against a
// non-bypassing and a bypassing instance sharing the same stimulus.
module tb_banco_reg_wb;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [1:0]  reg_dst;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1, read_data2, bRead1, bRead2;
    logic [4:0]  write_idx, bWriteIdx;
    logic [15:0] write_count, bWriteCount;

    banco_reg_wb #(.BYPASS(1'b0)) dut (
        .clk(clk), .reset(reset), .reg_write(reg_write), .reg_dst(reg_dst),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_idx(write_idx), .write_count(write_count)
    );

    banco_reg_wb #(.BYPASS(1'b1)) dutByp (
        .clk(clk), .reset(reset), .reg_write(reg_write), .reg_dst(reg_dst),
        .rt_addr(rt_addr), .rd_addr(rd_addr), .write_data(write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(bRead1), .read_data2(bRead2),
        .write_idx(bWriteIdx), .write_count(bWriteCount)
    );

    typedef enum int {SEL_RD1, SEL_RD2, SEL_WIDX, SEL_WCNT, SEL_BRD1, SEL_BRD2} sel_e;
    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sbQ[$];
    event sampleEv;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: drains every queued expectation against the live outputs.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(sampleEv);
            while (sbQ.size() > 0) begin
                c = sbQ.pop_front();
                case (c.sel)
                    SEL_RD1:  act = read_data1;
                    SEL_RD2:  act = read_data2;
                    SEL_WIDX: act = {27'd0, write_idx};
                    SEL_WCNT: act = {16'd0, write_count};
                    SEL_BRD1: act = bRead1;
                    SEL_BRD2: act = bRead2;
                    default:  act = 32'hxxxxxxxx;
                endcase
                total++;
                if (act !== c.exp) begin
                    bad++;
                    $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input sel_e sel, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.sel  = sel;
        c.exp  = exp;
        sbQ.push_back(c);
    endtask

    task automatic flushChecks();
        #1;
        -> sampleEv;
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] dst, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [31:0] data);
        @(negedge clk);
        reg_dst    = dst;
        rt_addr    = rt;
        rd_addr    = rd;
        write_data = data;
        reg_write  = 1'b1;
        @(posedge clk);
        #1;
        reg_write  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reg_write = 1'b0; reg_dst = 2'b00; rt_addr = '0; rd_addr = '0;
        write_data = '0; read_reg1 = '0; read_reg2 = '0;
        #2;

        // Reset contents on both ports
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i);
            read_reg2 = 5'(31 - i);
            checkOutput($sformatf("reset_rd1_r%0d", i), SEL_RD1, (i == 29) ? 32'd227 : 32'd0);
            checkOutput($sformatf("reset_rd2_r%0d", 31 - i), SEL_RD2, (31 - i == 29) ? 32'd227 : 32'd0);
            flushChecks();
        end
        checkOutput("reset_wcount", SEL_WCNT, 32'd0);
        checkOutput("reset_widx", SEL_WIDX, 32'd0);
        flushChecks();

        @(negedge clk);
        reset = 1'b0;

        // One write per reg_dst code
        applyStimulus(2'b00, 5'd8, 5'd9, 32'hDEADBEEF);
        applyStimulus(2'b01, 5'd8, 5'd9, 32'hDEADBEEF);
        applyStimulus(2'b10, 5'd8, 5'd9, 32'hDEADBEEF);
        applyStimulus(2'b11, 5'd8, 5'd9, 32'hDEADBEEF);
        read_reg1 = 5'd8; read_reg2 = 5'd9;
        checkOutput("dst_rt_r8", SEL_RD1, 32'hDEADBEEF);
        checkOutput("dst_rd_r9", SEL_RD2, 32'hDEADBEEF);
        flushChecks();
        read_reg1 = 5'd31; read_reg2 = 5'd29;
        checkOutput("dst_ra_r31", SEL_RD1, 32'hDEADBEEF);
        checkOutput("dst_sp_r29", SEL_RD2, 32'hDEADBEEF);
        checkOutput("dst_wcount", SEL_WCNT, 32'd4);
        checkOutput("dst_widx", SEL_WIDX, 32'd29);
        flushChecks();
        read_reg1 = 5'd10;
        checkOutput("untouched_r10", SEL_RD1, 32'd0);
        flushChecks();

        // Writes to $zero are discarded
        applyStimulus(2'b00, 5'd0, 5'd9, 32'hFFFFFFFF);
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        checkOutput("zero_rd1", SEL_RD1, 32'd0);
        checkOutput("zero_rd2", SEL_RD2, 32'd0);
        checkOutput("zero_byp_rd1", SEL_BRD1, 32'd0);
        checkOutput("zero_wcount", SEL_WCNT, 32'd4);
        checkOutput("zero_widx", SEL_WIDX, 32'd29);
        flushChecks();

        // Same-cycle read/write of reg 5, before and after the edge
        @(negedge clk);
        reg_dst = 2'b00; rt_addr = 5'd5; write_data = 32'h12345678; reg_write = 1'b1;
        read_reg1 = 5'd5; read_reg2 = 5'd5;
        checkOutput("same_pre_rd1", SEL_RD1, 32'd0);
        checkOutput("same_pre_rd2", SEL_RD2, 32'd0);
        checkOutput("same_pre_byp_rd1", SEL_BRD1, 32'h12345678);
        checkOutput("same_pre_byp_rd2", SEL_BRD2, 32'h12345678);
        flushChecks();
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        checkOutput("same_post_rd1", SEL_RD1, 32'h12345678);
        checkOutput("same_post_rd2", SEL_RD2, 32'h12345678);
        checkOutput("same_post_byp_rd1", SEL_BRD1, 32'h12345678);
        checkOutput("same_post_wcount", SEL_WCNT, 32'd5);
        checkOutput("same_post_widx", SEL_WIDX, 32'd5);
        flushChecks();

        // Async reset between edges overrides a pending write
        applyStimulus(2'b11, 5'd0, 5'd0, 32'h0000AAAA);
        read_reg1 = 5'd29;
        checkOutput("sp_written", SEL_RD1, 32'h0000AAAA);
        flushChecks();
        reg_dst = 2'b00; rt_addr = 5'd7; write_data = 32'h55; reg_write = 1'b1;
        reset = 1'b1;
        checkOutput("async_rst_sp", SEL_RD1, 32'd227);
        checkOutput("async_rst_wcount", SEL_WCNT, 32'd0);
        checkOutput("async_rst_widx", SEL_WIDX, 32'd0);
        flushChecks();
        @(posedge clk);
        #1;
        read_reg2 = 5'd7;
        checkOutput("rst_blocks_write_r7", SEL_RD2, 32'd0);
        checkOutput("rst_blocks_wcount", SEL_WCNT, 32'd0);
        flushChecks();

        // First edge after reset release accepts a write
        @(negedge clk);
        reset = 1'b0; reg_dst = 2'b00; rt_addr = 5'd4; write_data = 32'h44; reg_write = 1'b1;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        read_reg1 = 5'd4;
        checkOutput("first_write_r4", SEL_RD1, 32'h44);
        checkOutput("first_write_wcount", SEL_WCNT, 32'd1);
        checkOutput("first_write_widx", SEL_WIDX, 32'd4);
        flushChecks();

        // Counter wrap after 65536 writes to reg 3
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        read_reg1 = 5'd3;
        reg_dst = 2'b00; rt_addr = 5'd3;
        for (int i = 0; i < 65536; i++) begin
            @(negedge clk);
            write_data = 32'(i);
            reg_write  = 1'b1;
            if (i == 65535) begin
                checkOutput("wrap_pre_wcount", SEL_WCNT, 32'h0000FFFF);
                checkOutput("wrap_pre_r3", SEL_RD1, 32'h0000FFFE);
                flushChecks();
            end
        end
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        checkOutput("wrap_wcount", SEL_WCNT, 32'd0);
        checkOutput("wrap_r3", SEL_RD1, 32'h0000FFFF);
        checkOutput("wrap_widx", SEL_WIDX, 32'd3);
        flushChecks();

        if (sbQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
